// File: rtl/reram_pkg.sv
// Shared widths, sequencer state encoding and command record for the ReRAM
// command path.
package reram_pkg;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 5;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PROG,
    S_READ,
    S_RECOV
  } seq_state_e;

  typedef struct packed {
    logic              prog;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] data;
  } reram_cmd_t;

  localparam int CMD_W = $bits(reram_cmd_t);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reram_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; power-of-two depth so
// the pointers wrap naturally. Storage is cleared by reset so the head reads 0.
module reram_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // Full is judged on the registered count: a pop in the same cycle does not
  // open a slot for a push.
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/reram_cmd_sequencer.sv
// Replays queued program/read commands to the 32x32 ReRAM macro with
// multi-cycle strobe timing and queues read results for the bus side.
module reram_cmd_sequencer
  import reram_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int T_PROG    = 8,
  parameter int T_READ    = 3,
  parameter int T_RECOV   = 2
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_prog_i,
  input  logic [ROW_W-1:0]           cmd_row_i,
  input  logic [COL_W-1:0]           cmd_col_i,
  input  logic [DATA_W-1:0]          cmd_data_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic [ROW_W-1:0]           arr_row_o,
  output logic [COL_W-1:0]           arr_col_o,
  output logic [DATA_W-1:0]          arr_wdata_o,
  output logic                       arr_prog_o,
  output logic                       arr_read_o,
  input  logic [DATA_W-1:0]          arr_rdata_i,
  output logic                       busy_o,
  output logic [$clog2(CMD_DEPTH):0] cmd_level_o
);

  localparam int T_MAX  = max3(T_PROG, T_READ, T_RECOV);
  localparam int TMR_W  = $clog2(T_MAX) + 1;
  localparam int CMD_CW = $clog2(CMD_DEPTH) + 1;
  localparam int RSP_CW = $clog2(RSP_DEPTH) + 1;

  reram_cmd_t        cmd_in, cmd_head;
  logic [CMD_CW-1:0] cmd_count;
  logic [RSP_CW-1:0] rsp_count;
  logic              cmd_push, cmd_pop, rsp_push, rsp_pop;

  seq_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  reram_cmd_t        op_q, op_d;
  logic              prog_q, prog_d, read_q, read_d;

  assign cmd_in      = '{prog: cmd_prog_i, row: cmd_row_i, col: cmd_col_i, data: cmd_data_i};
  assign cmd_ready_o = (cmd_count != CMD_CW'(CMD_DEPTH));
  assign cmd_push    = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = (rsp_count != '0);
  assign rsp_pop     = rsp_valid_o && rsp_ready_i;

  reram_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n_i),
    .push_i  (cmd_push),
    .wdata_i (cmd_in),
    .pop_i   (cmd_pop),
    .rdata_o (cmd_head),
    .count_o (cmd_count)
  );

  reram_sync_fifo #(.WIDTH(DATA_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n_i),
    .push_i  (rsp_push),
    .wdata_i (arr_rdata_i),
    .pop_i   (rsp_pop),
    .rdata_o (rsp_data_o),
    .count_o (rsp_count)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      op_q    <= '0;
      prog_q  <= 1'b0;
      read_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      prog_q  <= prog_d;
      read_q  <= read_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    op_d     = op_q;
    cmd_pop  = 1'b0;
    rsp_push = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A read is only started once its result has a guaranteed slot; the
        // head stays put otherwise so commands never overtake each other.
        if (cmd_count != '0 && (cmd_head.prog || rsp_count != RSP_CW'(RSP_DEPTH))) begin
          cmd_pop = 1'b1;
          op_d    = cmd_head;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = op_q.prog ? S_PROG : S_READ;
        tmr_d   = op_q.prog ? TMR_W'(T_PROG - 1) : TMR_W'(T_READ - 1);
      end
      S_PROG: begin
        if (tmr_q == '0) begin
          state_d = S_RECOV;
          tmr_d   = TMR_W'(T_RECOV - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_READ: begin
        if (tmr_q == '0) begin
          rsp_push = 1'b1;
          state_d  = S_RECOV;
          tmr_d    = TMR_W'(T_RECOV - 1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_RECOV: begin
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - TMR_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they are
  // glitch-free and mutually exclusive by construction.
  always_comb begin
    prog_d = (state_d == S_PROG);
    read_d = (state_d == S_READ);
  end

  assign arr_prog_o  = prog_q;
  assign arr_read_o  = read_q;
  assign arr_row_o   = op_q.row;
  assign arr_col_o   = op_q.col;
  assign arr_wdata_o = op_q.data;
  assign busy_o      = (state_q != S_IDLE) || (cmd_count != '0);
  assign cmd_level_o = cmd_count;

endmodule

// File: tb/tb_reram_cmd_sequencer.sv
// Randomized bench for reram_cmd_sequencer: an array model answers reads, and
// an in-order scoreboard predicts executed ops and read responses.
module tb_reram_cmd_sequencer;
  import reram_pkg::*;

  localparam int TP = 8;
  localparam int TR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid_i = 1'b0, cmd_ready_o, cmd_prog_i = 1'b0;
  logic [4:0] cmd_row_i = '0, cmd_col_i = '0;
  logic [7:0] cmd_data_i = '0;
  logic       rsp_valid_o, rsp_ready_i = 1'b0;
  logic [7:0] rsp_data_o;
  logic [4:0] arr_row_o, arr_col_o;
  logic [7:0] arr_wdata_o, arr_rdata_i;
  logic       arr_prog_o, arr_read_o, busy_o;
  logic [2:0] cmd_level_o;

  always #5 clk = ~clk;

  reram_cmd_sequencer #(
    .CMD_DEPTH(4), .RSP_DEPTH(4), .T_PROG(TP), .T_READ(TR), .T_RECOV(2)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_prog_i(cmd_prog_i),
    .cmd_row_i(cmd_row_i), .cmd_col_i(cmd_col_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .arr_row_o(arr_row_o), .arr_col_o(arr_col_o), .arr_wdata_o(arr_wdata_o),
    .arr_prog_o(arr_prog_o), .arr_read_o(arr_read_o), .arr_rdata_i(arr_rdata_i),
    .busy_o(busy_o), .cmd_level_o(cmd_level_o)
  );

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] arr_mem [32][32];
  logic [7:0] sb_mem  [32][32];
  reram_cmd_t exp_ops[$], exec_ops[$], stim[$];
  logic [7:0] exp_rsp[$], act_rsp[$];
  int prog_run = 0, read_run = 0, prog_len_bad = 0, read_len_bad = 0;
  int overlap_cnt = 0, ready_bad = 0, max_level = 0;
  logic prev_prog = 1'b0, prev_read = 1'b0;

  assign arr_rdata_i = arr_read_o ? arr_mem[arr_row_o][arr_col_o] : 8'h00;

  // Array macro model, strobe monitor and in-order scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_prog = 1'b0; prev_read = 1'b0; prog_run = 0; read_run = 0;
    end else begin
      if (arr_prog_o && arr_read_o) overlap_cnt++;
      if (arr_prog_o) begin
        if (!prev_prog) exec_ops.push_back('{1'b1, arr_row_o, arr_col_o, arr_wdata_o});
        prog_run++;
        arr_mem[arr_row_o][arr_col_o] = arr_wdata_o;
      end else if (prev_prog) begin
        if (prog_run != TP) prog_len_bad++;
        prog_run = 0;
      end
      if (arr_read_o) begin
        if (!prev_read) exec_ops.push_back('{1'b0, arr_row_o, arr_col_o, 8'h00});
        read_run++;
      end else if (prev_read) begin
        if (read_run != TR) read_len_bad++;
        read_run = 0;
      end
      prev_prog = arr_prog_o;
      prev_read = arr_read_o;
      if (cmd_ready_o !== (cmd_level_o != 3'd4)) ready_bad++;
      if (int'(cmd_level_o) > max_level) max_level = int'(cmd_level_o);
      if (cmd_valid_i && cmd_ready_o) begin
        exp_ops.push_back('{cmd_prog_i, cmd_row_i, cmd_col_i, cmd_prog_i ? cmd_data_i : 8'h00});
        if (cmd_prog_i) sb_mem[cmd_row_i][cmd_col_i] = cmd_data_i;
        else            exp_rsp.push_back(sb_mem[cmd_row_i][cmd_col_i]);
      end
      if (rsp_valid_o && rsp_ready_i) act_rsp.push_back(rsp_data_o);
    end
  end

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic clear_queues();
    exp_ops.delete(); exec_ops.delete(); stim.delete();
    exp_rsp.delete(); act_rsp.delete();
  endtask

  // Caller must be aligned just after a rising edge; returns 1ns after the
  // accepting edge so consecutive calls stream one command per cycle.
  task automatic push_cmd(input logic p, input logic [4:0] r, input logic [4:0] c,
                          input logic [7:0] d);
    int g = 0;
    cmd_valid_i = 1'b1; cmd_prog_i = p; cmd_row_i = r; cmd_col_i = c; cmd_data_i = d;
    stim.push_back('{p, r, c, p ? d : 8'h00});
    @(negedge clk);
    while (!cmd_ready_o && g < 500) begin @(negedge clk); g++; end
    if (!cmd_ready_o) begin
      n_checks++; n_fail++;
      $display("FAIL push_timeout: cmd_ready_o=%0b required 1", cmd_ready_o);
    end
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    @(negedge clk);
    while (busy_o && k < max_cyc) begin @(negedge clk); k++; end
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: busy_o=%0b required 0", busy_o);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (arr_prog_o !== 1'b0 || arr_read_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_strobes: prog=%0b read=%0b required 0 0", arr_prog_o, arr_read_o);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b required 1", cmd_ready_o); end
    n_checks++;
    if ({rsp_valid_o, busy_o, cmd_level_o} !== 5'd0) begin
      n_fail++; $display("FAIL rst_status: rsp_valid=%0b busy=%0b level=%0d required 0 0 0",
                         rsp_valid_o, busy_o, cmd_level_o);
    end
    n_checks++;
    if ({arr_row_o, arr_col_o, arr_wdata_o, rsp_data_o} !== 26'd0) begin
      n_fail++; $display("FAIL rst_data: row=%0h col=%0h wdata=%0h rsp=%0h required 0",
                         arr_row_o, arr_col_o, arr_wdata_o, rsp_data_o);
    end
  endtask

  task automatic test_program();
    int bad = 0;
    sync();
    push_cmd(1'b1, 5'd2, 5'd3, 8'hEF);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (arr_prog_o !== (k >= 2 && k <= 9) || arr_read_o !== 1'b0) bad++;
      if (k == 2) begin
        n_checks++;
        if (arr_row_o !== 5'd2 || arr_col_o !== 5'd3 || arr_wdata_o !== 8'hEF) begin
          n_fail++; $display("FAIL prog_addr: row=%0d col=%0d wdata=%0h required 2 3 ef",
                             arr_row_o, arr_col_o, arr_wdata_o);
        end
      end
      if (k == 11) begin
        n_checks++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL prog_busy_recov: got %0b required 1", busy_o); end
      end
      if (k == 12) begin
        n_checks++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL prog_busy_end: got %0b required 0", busy_o); end
      end
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL prog_window: %0d bad cycles required 0", bad); end
  endtask

  task automatic test_read();
    int bad = 0;
    rsp_ready_i = 1'b0;
    sync();
    push_cmd(1'b0, 5'd2, 5'd3, 8'h00);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (rsp_valid_o !== (k >= 5)) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL read_latency: %0d bad cycles required 0", bad); end
    n_checks++;
    if (rsp_data_o !== 8'hEF) begin n_fail++; $display("FAIL read_data: got %0h required ef", rsp_data_o); end
    sync(); rsp_ready_i = 1'b1;
    sync(); rsp_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL read_pop: rsp_valid=%0b required 0", rsp_valid_o); end
    wait_idle(50);
  endtask

  task automatic test_back_to_back();
    clear_queues();
    rsp_ready_i = 1'b1;
    max_level = 0;
    sync();
    for (int i = 0; i < 6; i++)
      push_cmd(1'b1, 5'($urandom_range(0, 30)), 5'($urandom_range(0, 30)), 8'($urandom));
    wait_idle(400);
    n_checks++;
    if (max_level != 4) begin n_fail++; $display("FAIL b2b_full_level: got %0d required 4", max_level); end
    n_checks++;
    if (exec_ops.size() != 6 || exp_ops.size() != 6) begin
      n_fail++; $display("FAIL b2b_count: executed=%0d accepted=%0d required 6 6", exec_ops.size(), exp_ops.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (exec_ops[i] !== stim[i]) begin
          n_fail++; $display("FAIL b2b_order[%0d]: got %0h required %0h", i, exec_ops[i], stim[i]);
        end
      end
    end
  endtask

  task automatic test_rsp_full();
    int rd_late = 0;
    reram_cmd_t cells[$];
    cells = stim;
    clear_queues();
    rsp_ready_i = 1'b0;
    sync();
    for (int i = 0; i < 5; i++)
      push_cmd(1'b0, cells[i].row, cells[i].col, 8'h00);
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (k >= 40 && arr_read_o !== 1'b0) rd_late++;
    end
    n_checks++;
    if (exec_ops.size() != 4) begin n_fail++; $display("FAIL full_reads_done: got %0d required 4", exec_ops.size()); end
    n_checks++;
    if (rd_late != 0) begin n_fail++; $display("FAIL full_stall_strobe: %0d read cycles required 0", rd_late); end
    n_checks++;
    if (cmd_level_o !== 3'd1 || busy_o !== 1'b1 || rsp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL full_stall_state: level=%0d busy=%0b rsp_valid=%0b required 1 1 1",
                         cmd_level_o, busy_o, rsp_valid_o);
    end
    n_checks++;
    if (rsp_data_o !== exp_rsp[0]) begin n_fail++; $display("FAIL full_head: got %0h required %0h", rsp_data_o, exp_rsp[0]); end
    sync(); rsp_ready_i = 1'b1;
    sync(); rsp_ready_i = 1'b0;
    wait_idle(60);
    n_checks++;
    if (exec_ops.size() != 5) begin n_fail++; $display("FAIL full_resume: got %0d reads required 5", exec_ops.size()); end
    sync(); rsp_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (act_rsp.size() != 5 || exp_rsp.size() != 5) begin
      n_fail++; $display("FAIL full_rsp_count: got %0d required 5", act_rsp.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (act_rsp[i] !== exp_rsp[i]) begin
          n_fail++; $display("FAIL full_rsp[%0d]: got %0h required %0h", i, act_rsp[i], exp_rsp[i]);
        end
      end
    end
  endtask

  task automatic test_mixed();
    reram_cmd_t progs[$];
    int idx;
    clear_queues();
    rsp_ready_i = 1'b1;
    sync();
    for (int i = 0; i < 32; i++) begin
      reram_cmd_t c;
      c = '{1'b1, 5'($urandom_range(0, 30)), 5'($urandom_range(0, 30)), 8'($urandom)};
      progs.push_back(c);
      push_cmd(1'b1, c.row, c.col, c.data);
    end
    for (int i = 0; i < 5; i++) begin
      idx = $urandom_range(0, 31);
      push_cmd(1'b0, progs[idx].row, progs[idx].col, 8'h00);
    end
    wait_idle(2000);
    repeat (4) @(negedge clk);
    n_checks++;
    if (exec_ops.size() != stim.size()) begin
      n_fail++; $display("FAIL mix_exec_count: got %0d required %0d", exec_ops.size(), stim.size());
    end else begin
      int bad = 0;
      foreach (stim[i]) if (exec_ops[i] !== stim[i]) bad++;
      n_checks++;
      if (bad != 0) begin n_fail++; $display("FAIL mix_exec_order: %0d ops differ required 0", bad); end
    end
    n_checks++;
    if (act_rsp.size() != 5) begin
      n_fail++; $display("FAIL mix_rsp_count: got %0d required 5", act_rsp.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (act_rsp[i] !== exp_rsp[i]) begin
          n_fail++; $display("FAIL mix_rsp[%0d]: got %0h required %0h", i, act_rsp[i], exp_rsp[i]);
        end
      end
    end
    n_checks++;
    if (overlap_cnt != 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d required 0", overlap_cnt); end
    n_checks++;
    if (prog_len_bad != 0 || read_len_bad != 0) begin
      n_fail++; $display("FAIL strobe_len: prog_bad=%0d read_bad=%0d required 0 0", prog_len_bad, read_len_bad);
    end
    n_checks++;
    if (ready_bad != 0) begin n_fail++; $display("FAIL ready_vs_level: got %0d bad cycles required 0", ready_bad); end
  endtask

  task automatic test_reset_mid_op();
    int g = 0;
    rsp_ready_i = 1'b1;
    sync();
    push_cmd(1'b1, 5'd31, 5'd31, 8'hAA);
    push_cmd(1'b0, 5'd2, 5'd3, 8'h00);
    push_cmd(1'b0, 5'd2, 5'd3, 8'h00);
    @(negedge clk);
    while (!arr_prog_o && g < 30) begin @(negedge clk); g++; end
    n_checks++;
    if (arr_prog_o !== 1'b1 || cmd_level_o !== 3'd2) begin
      n_fail++; $display("FAIL midop_setup: prog=%0b level=%0d required 1 2", arr_prog_o, cmd_level_o);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (arr_prog_o !== 1'b0) begin n_fail++; $display("FAIL midop_async_drop: prog=%0b required 0", arr_prog_o); end
    n_checks++;
    if (cmd_level_o !== 3'd0) begin n_fail++; $display("FAIL midop_flush: level=%0d required 0", cmd_level_o); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    clear_queues();
    @(negedge clk);
    n_checks++;
    if (cmd_ready_o !== 1'b1 || cmd_level_o !== 3'd0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL midop_after: ready=%0b level=%0d rsp_valid=%0b busy=%0b required 1 0 0 0",
                         cmd_ready_o, cmd_level_o, rsp_valid_o, busy_o);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (exec_ops.size() != 0 || act_rsp.size() != 0) begin
      n_fail++; $display("FAIL midop_discard: ops=%0d rsps=%0d required 0 0", exec_ops.size(), act_rsp.size());
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        arr_mem[r][c] = 8'h00;
        sb_mem[r][c]  = 8'h00;
      end
    test_reset();
    test_program();
    test_read();
    test_back_to_back();
    test_rsp_full();
    test_mixed();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
